// File: rtl/wake_arbiter.sv
// rtl/wake_arbiter.sv - round-robin arbiter sequencing wake-up pulses onto a shared Trig trigger line
//
// Four level-sensitive requesters share one wake_up line. Each grant produces one
// PULSE_W-cycle wake-up pulse. The line is then held low for WINDOW cycles, and
// GAP more guard cycles follow before the next arbitration. This keeps successive
// wake-ups out of an open Trig window.
//
// Ports:
//   clki         clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       gates new grants only; a service already running always completes
//   req[3:0]     level requests, sampled only while idle
//   grant[3:0]   one-hot, high for PULSE_W + WINDOW cycles
//   gnt_idx[1:0] index of the most recent grant, held until the next grant
//   wake_up      trigger pulse to Trig.wake_up
//   done         one-cycle pulse, rises on the edge where grant falls
//   busy         high whenever not idle
//   issue_count  wrapping count of wake-up pulses issued
module wake_arbiter #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned WINDOW  = 14000,
    parameter int unsigned GAP     = 16
) (
    input  logic        clki,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  req,
    output logic [3:0]  grant,
    output logic [1:0]  gnt_idx,
    output logic        wake_up,
    output logic        done,
    output logic        busy,
    output logic [19:0] issue_count
);

    localparam logic [19:0] PULSE_LAST  = 20'(PULSE_W - 1);
    localparam logic [19:0] WINDOW_LAST = 20'(WINDOW - 1);
    localparam logic [19:0] GAP_LAST    = 20'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WINDOW,
        S_GAP
    } state_t;

    state_t      state;
    logic [19:0] cnt;

    // Round-robin pick: search upward from the slot after the last grant.
    // The last-granted slot is examined last, so a requester that holds req
    // high waits until every other pending requester has been served once.
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       pick_valid;

    always_comb begin
        pick_idx   = gnt_idx;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = gnt_idx + 2'(k);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            grant       <= '0;
            gnt_idx     <= 2'd3;  // makes req[0] the first priority after reset
            wake_up     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            issue_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && pick_valid) begin
                        grant       <= 4'b0001 << pick_idx;
                        gnt_idx     <= pick_idx;
                        wake_up     <= 1'b1;
                        busy        <= 1'b1;
                        issue_count <= issue_count + 20'd1;
                        cnt         <= '0;
                        state       <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        wake_up <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WINDOW;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                S_WINDOW: begin
                    if (cnt == WINDOW_LAST) begin
                        grant <= '0;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                S_GAP: begin
                    done <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wake_arbiter.sv
// tb/tb_wake_arbiter.sv - scoreboard bench for wake_arbiter with a behavioural grant-order model
module tb_wake_arbiter;

    localparam int PW  = 3;
    localparam int WN  = 8;
    localparam int GP  = 2;
    localparam int SVC = PW + WN + GP + 1;  // edges between consecutive grants

    logic        clki = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  grant;
    logic [1:0]  gnt_idx;
    logic        wake_up;
    logic        done;
    logic        busy;
    logic [19:0] issue_count;

    always #5 clki = ~clki;

    wake_arbiter #(
        .PULSE_W(PW),
        .WINDOW (WN),
        .GAP    (GP)
    ) dut (
        .clki       (clki),
        .rst_n      (rst_n),
        .enable     (enable),
        .req        (req),
        .grant      (grant),
        .gnt_idx    (gnt_idx),
        .wake_up    (wake_up),
        .done       (done),
        .busy       (busy),
        .issue_count(issue_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int preload_gen = 0;

    always @(posedge clki) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int idx;
        int count;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a grant happens on the next edge whenever the arbiter is
    // free, enabled and something is requested; it is free again SVC edges later.
    int m_last = 3;
    int m_free = 0;
    int m_count = 0;
    int seen_gen = 0;

    always @(negedge clki) begin
        int   idx;
        bit   found;
        exp_t e;
        if (!rst_n) begin
            m_last  = 3;
            m_free  = 0;
            m_count = 0;
            exp_q.delete();
        end else begin
            if (preload_gen != seen_gen) begin
                seen_gen = preload_gen;
                m_count  = 'hFFFFF;
            end
            if (enable && req != 4'b0000 && cyc + 1 >= m_free) begin
                found = 1'b0;
                idx   = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && req[(m_last + k) % 4]) begin
                        found = 1'b1;
                        idx   = (m_last + k) % 4;
                    end
                end
                m_last    = idx;
                m_count   = (m_count + 1) % (1 << 20);
                e.idx     = idx;
                e.count   = m_count;
                e.edge_no = cyc + 1;
                exp_q.push_back(e);
                m_free    = cyc + 1 + SVC;
            end
        end
    end

    // Monitor: pops one expectation per wake_up rise and measures output widths.
    logic prev_wu = 1'b0;
    int   wu_len = 0;
    int   gr_len = 0;
    int   dn_len = 0;
    int   bz_len = 0;

    always @(negedge clki) begin
        exp_t e;
        if (!rst_n) begin
            prev_wu = 1'b0;
            wu_len  = 0;
            gr_len  = 0;
            dn_len  = 0;
            bz_len  = 0;
        end else begin
            if (wake_up && !prev_wu) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_wake: got grant %b at cycle %0d, expected none", grant, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_onehot", int'(grant), 1 << e.idx);
                    check("gnt_idx", int'(gnt_idx), e.idx);
                    check("issue_count", int'(issue_count), e.count);
                    check("rise_edge", cyc, e.edge_no);
                end
            end
            if (wake_up) wu_len++;
            else if (wu_len > 0) begin
                check("wake_width", wu_len, PW);
                wu_len = 0;
            end
            if (grant != 4'b0000) gr_len++;
            else if (gr_len > 0) begin
                check("grant_width", gr_len, PW + WN);
                check("done_at_grant_fall", int'(done), 1);
                gr_len = 0;
            end
            if (done) dn_len++;
            else if (dn_len > 0) begin
                check("done_width", dn_len, 1);
                dn_len = 0;
            end
            if (busy) bz_len++;
            else if (bz_len > 0) begin
                check("busy_width", bz_len, PW + WN + GP);
                bz_len = 0;
            end
            prev_wu = wake_up;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clki);
        @(posedge clki);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_grant"}, int'(grant), 0);
        check({tag, "_gnt_idx"}, int'(gnt_idx), 3);
        check({tag, "_wake_up"}, int'(wake_up), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_issue_count"}, int'(issue_count), 0);
    endtask

    initial begin
        // Reset state
        step(3);
        check_reset_state("reset");
        rst_n = 1'b1;
        step(1);

        // Single request held one cycle
        enable = 1'b1;
        req    = 4'b0001;
        step(1);
        req    = 4'b0000;
        step(20);
        check("single_count", int'(issue_count), 1);

        // Round-robin with all requests held
        do_reset();
        req = 4'b1111;
        step(5 * SVC);
        req = 4'b0000;
        step(20);

        // Fairness: req[1] joins after the first grant
        do_reset();
        req = 4'b0101;
        step(1);
        req = 4'b0111;
        step(4 * SVC - 2);
        req = 4'b0000;
        step(20);

        // Enable gating, then request dropped during PULSE
        do_reset();
        enable = 1'b0;
        req    = 4'b0010;
        step(10);
        check("disabled_busy", int'(busy), 0);
        check("disabled_grant", int'(grant), 0);
        enable = 1'b1;
        step(1);
        check("enable_grant", int'(grant), 4'b0010);
        req = 4'b0000;
        step(20);

        // Asynchronous reset in the middle of WINDOW
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clki);
        @(posedge clki);
        #1;
        rst_n = 1'b1;
        req   = 4'b1000;
        step(1);
        check("post_reset_grant", int'(grant), 4'b1000);
        check("post_reset_idx", int'(gnt_idx), 3);
        req = 4'b0000;
        step(20);

        // issue_count wrap
        force dut.issue_count = 20'hFFFFF;
        #1;
        release dut.issue_count;
        preload_gen++;
        check("preload_count", int'(issue_count), 'hFFFFF);
        step(1);
        req = 4'b0001;
        step(1);
        check("wrap_count", int'(issue_count), 0);
        req = 4'b0000;
        step(20);

        // Randomised requests and enable
        do_reset();
        repeat (800) begin
            enable = ($urandom_range(0, 3) != 0);
            req    = 4'($urandom_range(0, 15));
            step(1);
        end
        req = 4'b0000;
        begin
            int n;
            n = 0;
            while ((busy || exp_q.size() != 0) && n < 100) begin
                step(1);
                n++;
            end
            step(2);
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
